fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one 16-deep x 8-bit FIFO write port among NREQ producers.
- Grants one producer at a time for a bounded burst, then moves on to the next.
- Gates every transfer on the FIFO full flag, so a write is never issued into a full FIFO and the FIFO's overflow flag stays clear.
- Sits between the producer blocks and the FIFO's wr/data_in/fifo_full ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width per requester.
- BURST_MAX, 4, maximum words accepted per grant (1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester "has word" level; bit i owns slice i of req_data.
- req_data  input  NREQ*DW  flattened data; word i = req_data[i*DW +: DW].
- ack  output  NREQ  per-requester accept strobe; combinational; word consumed this cycle.
- gnt  output  NREQ  one-hot registered grant; zero when idle.
- busy  output  1  high while a grant is held.
- fifo_full  input  1  FIFO full flag.
- fifo_wr  output  1  FIFO write strobe; combinational.
- fifo_wdata  output  DW  FIFO write data, muxed from the owner's slice.

Behaviour:
- Reset (async, rst_n low): state=IDLE, gnt=0, busy=0, burst count=0, last-owner pointer=NREQ-1, so requester 0 wins first. Combinational outputs fifo_wr=0 and ack=0 follow from gnt=0.
- Reset mid-burst: immediate return to IDLE. A word presented in the reset cycle is not written.
- State IDLE:
  - busy=0, gnt=0, fifo_wr=0.
  - If |req, choose the first set bit searching from (last+1) mod NREQ upward with wrap.
  - Next edge: gnt<=onehot(winner), last<=winner, count<=0, state<=BURST.
  - Arbitration latency is 1 cycle from req rise to gnt.
- State BURST (owner o):
  - busy=1.
  - fifo_wr = req[o] & ~fifo_full; ack[o] = fifo_wr; all other ack bits are 0.
  - fifo_wdata = word o whenever busy; 0 in IDLE.
  - Each cycle with fifo_wr=1: count<=count+1.
- Release at the edge, to IDLE with gnt<=0, when either:
  - req[o]=0, or
  - fifo_wr=1 and count==BURST_MAX-1 (the BURST_MAX-th accepted word).
- Release always costs one IDLE cycle before the next grant. The next grant starts searching after o, which guarantees fairness.
- fifo_full high in BURST:
  - Hold the grant.
  - No write, no ack, count unchanged.
  - No timeout; the owner keeps its grant until the FIFO drains.
- Requester drops req while stalled by fifo_full: release per the rule above.
- req changes on non-owners during BURST are ignored; they are re-sampled only in IDLE.
- Single requester continuously asserting req: bursts of BURST_MAX words separated by 1 idle cycle. Throughput is BURST_MAX/(BURST_MAX+1).
- Count width: clog2(BURST_MAX+1). Count never exceeds BURST_MAX-1.
- Invariants:
  - gnt is one-hot or zero.
  - fifo_wr implies |gnt and ~fifo_full.
  - ack is one-hot or zero and equals gnt & {NREQ{fifo_wr}}.

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_DEPTH=16 and FIFO_DW=8.
  - State encoding ARB_IDLE=1'b0, ARB_BURST=1'b1.
- One sub-module rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req[NREQ], last index. Outputs: winner index, valid.
  - Implemented as a rotate, priority encode, then un-rotate.
  - Reusable by a future read-side scheduler.

Test Plan:
- Reset with req=4'b1111 held: gnt=0 during reset; first edge after release gives gnt=0001; then 4 acks on requester 0; then 1 idle cycle; then gnt=0010.
- Single requester 2 continuously asserting req, data 8'h20..8'h27: FIFO receives 20,21,22,23 with gnt=0100, then 1 cycle gnt=0, then 24..27; 8 fifo_wr pulses in 10 cycles.
- Requester 1 drops req after 2 accepted words: gnt released after word 2, count resets; next grant goes to requester 2 if it is requesting, else requester 3, 0, 1 in order.
- fifo_full forced high for 5 cycles mid-burst (owner 3 after word 1): fifo_wr=0, ack=0, gnt stays 1000 for 5 cycles; after fifo_full falls, 3 more words are written and the FIFO never overflows.
- All four requesters active, 40 cycles against a FIFO that drains every cycle:
  - Grant order is 0,1,2,3,0...
  - Each requester receives exactly 4 words per round.
  - The scoreboard sees FIFO output equal to arbitration order.
- Async reset asserted mid-burst (owner 1 at count=2): gnt, busy and fifo_wr drop immediately without waiting for clk; after reset release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO geometry and write-arbiter state encoding
package fifo_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_DW    = 8;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO-side signal bundle of the write arbiter
interface fifo_wr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    ack;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic               fifo_full;
   logic               fifo_wr;
   logic [DW-1:0]      fifo_wdata;

   // arbiter side
   modport master (
      input  req, req_data, fifo_full,
      output ack, gnt, busy, fifo_wr, fifo_wdata
   );

   // producers plus FIFO side
   modport slave (
      output req, req_data, fifo_full,
      input  ack, gnt, busy, fifo_wr, fifo_wdata
   );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker (rotate, priority encode, un-rotate)
module rr_pick #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [IW-1:0] winner_o,
   output logic          valid_o
);

   logic [N-1:0]  rot;
   logic [IW-1:0] off;

   // rotate so the slot after last_i lands on bit 0, take the lowest set bit, map it back
   always_comb begin
      rot = '0;
      off = '0;
      for (int k = 0; k < N; k++) begin
         rot[k] = req_i[IW'((int'(last_i) + 1 + k) % N)];
      end
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) off = IW'(k);
      end
      valid_o  = |rot;
      winner_o = IW'((int'(last_i) + 1 + int'(off)) % N);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int DW        = FIFO_DW,
   parameter int BURST_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   fifo_wr_arbiter_if.master   bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(BURST_MAX + 1);

   arb_state_e      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]   last_q, last_d;   // doubles as the owner index while in BURST
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [IW-1:0]   pick_idx;
   logic            pick_vld;
   logic            busy;
   logic            wr;
   logic [DW-1:0]   wdata;

   rr_pick #(.N(NREQ)) u_pick (
      .req_i    (bus.req),
      .last_i   (last_q),
      .winner_o (pick_idx),
      .valid_o  (pick_vld)
   );

   // state register; last starts at NREQ-1 so requester 0 is searched first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         last_q  <= IW'(NREQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state: grant the picked winner from IDLE, count accepted words and release in BURST
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_vld) begin
               state_d = ARB_BURST;
               gnt_d   = NREQ'(1) << pick_idx;
               last_d  = pick_idx;
               cnt_d   = '0;
            end
         end
         ARB_BURST: begin
            if (wr) cnt_d = cnt_q + CW'(1);
            if (!bus.req[last_q] || (wr && cnt_q == CW'(BURST_MAX - 1))) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // outputs: write only while the owner has a word and the FIFO has room
   always_comb begin
      busy  = (state_q == ARB_BURST);
      wr    = busy & bus.req[last_q] & ~bus.fifo_full;
      wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (busy && last_q == IW'(i)) wdata = bus.req_data[i*DW +: DW];
      end
   end

   assign bus.busy       = busy;
   assign bus.gnt        = gnt_q;
   assign bus.fifo_wr    = wr;
   assign bus.ack        = gnt_q & {NREQ{wr}};
   assign bus.fifo_wdata = wdata;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
   import fifo_pkg::*;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int BM   = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int              vecs = 0;
   int              errs = 0;
   logic [NREQ-1:0] en = '0;
   int              lim [NREQ];
   int              sent [NREQ];
   logic            clr = 1'b1;
   logic            force_full = 1'b0;
   int              occ = 0;
   int              wr_cnt = 0;
   logic [7:0]      expq [$];
   logic [NREQ-1:0] gq [$];

   // producer i offers word {i, sent[i]} while enabled and below its limit
   always_comb begin
      bus.req      = '0;
      bus.req_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req[i]              = en[i] && (sent[i] < lim[i]);
         bus.req_data[i*DW +: DW] = {4'(i), 4'(sent[i])};
      end
   end

   assign bus.fifo_full = force_full | (occ >= FIFO_DEPTH);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // producers advance on the ack seen in the cycle before the edge
   initial begin
      logic [NREQ-1:0] a;
      for (int i = 0; i < NREQ; i++) sent[i] = 0;
      forever begin
         @(negedge clk);
         a = bus.ack;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (clr) sent[i] = 0;
            else if (a[i]) sent[i]++;
         end
      end
   end

   // FIFO occupancy model draining one word per cycle
   initial begin
      logic w;
      forever begin
         @(negedge clk);
         w = bus.fifo_wr && rst_n;
         @(posedge clk);
         #1;
         occ = occ + (w ? 1 : 0);
         if (occ > 0) occ--;
      end
   end

   // monitor: every FIFO write pops the scoreboard
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.fifo_wr) begin
            wr_cnt++;
            check("no_write_when_full", 32'(bus.fifo_full), 0);
            if (expq.size() == 0) begin
               vecs++;
               errs++;
               $display("FAIL unexpected_write: got %0h expected none", bus.fifo_wdata);
            end else begin
               e = expq.pop_front();
               check("fifo_wdata", 32'(bus.fifo_wdata), 32'(e));
               check("ack_onehot", 32'(bus.ack), 32'(1) << e[7:4]);
               check("gnt_owner", 32'(bus.gnt), 32'(1) << e[7:4]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_cycle(input string name);
      logic [NREQ-1:0] g;
      @(negedge clk);
      if (gq.size() > 0) begin
         g = gq.pop_front();
         check(name, 32'(bus.gnt), 32'(g));
      end
   endtask

   task automatic push_g(input logic [NREQ-1:0] g, input int n);
      for (int k = 0; k < n; k++) gq.push_back(g);
   endtask

   task automatic push_w(input int r, input int first, input int n);
      for (int k = 0; k < n; k++) expq.push_back({4'(r), 4'(first + k)});
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (expq.size() > 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(expq.size()), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr = 1'b1;
      en = '0;
      force_full = 1'b0;
      for (int i = 0; i < NREQ; i++) lim[i] = 0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_gnt", 32'(bus.gnt), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_fifo_wr", 32'(bus.fifo_wr), 0);
      expq.delete();
      gq.delete();
      clr = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int w0;

      // reset held with all four requesting, then 0 bursts and 1 follows after an idle cycle
      do_reset();
      en = 4'b1111;
      for (int i = 0; i < NREQ; i++) lim[i] = 4;
      step(); step();
      check("t1_gnt_in_reset", 32'(bus.gnt), 0);
      check("t1_ack_in_reset", 32'(bus.ack), 0);
      for (int r = 0; r < NREQ; r++) push_w(r, 0, 4);
      push_g(4'b0000, 1); push_g(4'b0001, 4); push_g(4'b0000, 1); push_g(4'b0010, 1);
      rst_n = 1'b1;
      chk_cycle("t1_gnt");
      repeat (6) begin step(); chk_cycle("t1_gnt"); end
      drain("t1_drain");

      // single requester 2 streaming: two bursts split by one idle cycle
      do_reset();
      en = 4'b0100; lim[2] = 8;
      push_w(2, 0, 8);
      push_g(4'b0000, 1); push_g(4'b0100, 4); push_g(4'b0000, 1); push_g(4'b0100, 4); push_g(4'b0000, 1);
      rst_n = 1'b1;
      chk_cycle("t2_gnt");
      w0 = wr_cnt;
      repeat (10) begin step(); chk_cycle("t2_gnt"); end
      check("t2_wr_pulses", 32'(wr_cnt - w0), 8);
      drain("t2_drain");

      // requester 1 drops after two words, grant moves on to 2
      do_reset();
      en = 4'b0110; lim[1] = 2; lim[2] = 4;
      push_w(1, 0, 2); push_w(2, 0, 4);
      push_g(4'b0000, 1); push_g(4'b0010, 3); push_g(4'b0000, 1); push_g(4'b0100, 4); push_g(4'b0000, 1);
      rst_n = 1'b1;
      chk_cycle("t3_gnt");
      repeat (9) begin step(); chk_cycle("t3_gnt"); end
      drain("t3_drain");

      // FIFO full for five cycles after owner 3's first word
      do_reset();
      en = 4'b1000; lim[3] = 4;
      push_w(3, 0, 4);
      push_g(4'b0000, 1); push_g(4'b1000, 9); push_g(4'b0000, 1);
      rst_n = 1'b1;
      chk_cycle("t4_gnt");
      for (int n = 1; n <= 10; n++) begin
         step();
         if (n == 2) force_full = 1'b1;
         if (n == 7) force_full = 1'b0;
         chk_cycle("t4_gnt");
         if (n >= 2 && n <= 6) begin
            check("t4_stall_wr", 32'(bus.fifo_wr), 0);
            check("t4_stall_ack", 32'(bus.ack), 0);
         end
      end
      drain("t4_drain");

      // all four requesting for two full rounds
      do_reset();
      en = 4'b1111;
      for (int i = 0; i < NREQ; i++) lim[i] = 8;
      for (int rnd = 0; rnd < 2; rnd++)
         for (int r = 0; r < NREQ; r++) push_w(r, rnd * 4, 4);
      push_g(4'b0000, 1);
      for (int k = 0; k < 8; k++) begin
         push_g(4'(1 << (k % 4)), 4);
         push_g(4'b0000, 1);
      end
      rst_n = 1'b1;
      chk_cycle("t5_gnt");
      repeat (40) begin step(); chk_cycle("t5_gnt"); end
      drain("t5_drain");

      // asynchronous reset with owner 1 at count 2, then restart at requester 0
      do_reset();
      en = 4'b0010; lim[1] = 8;
      push_w(1, 0, 2);
      push_g(4'b0000, 1); push_g(4'b0010, 2);
      rst_n = 1'b1;
      chk_cycle("t6_gnt");
      for (int n = 1; n <= 3; n++) begin
         step();
         if (n == 3) begin
            #1 rst_n = 1'b0;
            #1;
            check("t6_async_gnt", 32'(bus.gnt), 0);
            check("t6_async_busy", 32'(bus.busy), 0);
            check("t6_async_wr", 32'(bus.fifo_wr), 0);
         end
         chk_cycle("t6_gnt");
      end
      check("t6_pre_drain", 32'(expq.size()), 0);
      en = 4'b0011; lim[0] = 1;
      push_w(0, 0, 1); push_w(1, 2, 6);
      step(); step();
      push_g(4'b0000, 1); push_g(4'b0001, 2); push_g(4'b0000, 1); push_g(4'b0010, 4);
      push_g(4'b0000, 1); push_g(4'b0010, 3); push_g(4'b0000, 1);
      rst_n = 1'b1;
      chk_cycle("t6_restart_gnt");
      repeat (12) begin step(); chk_cycle("t6_restart_gnt"); end
      drain("t6_drain");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
